mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs the data-memory access for loads and stores over a req/ack handshake to a variable-latency data memory.
- Stalls upstream stages until the access completes, and resolves branches.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
TIMEOUT_CYCLES, 1023, max cycles in WAIT without mem_ack_i before aborting (1..65535)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-low reset
ALUResult_i  in  32  EX/MEM ALU result / memory address
RS2data_i  in  32  EX/MEM store data
Zero_i  in  1  EX/MEM ALU zero flag
pc_branch_i  in  32  EX/MEM branch target
Branch_i  in  1  EX/MEM branch control
MemRead_i  in  1  EX/MEM load control
MemtoReg_i  in  1  EX/MEM writeback select
MemWrite_i  in  1  EX/MEM store control
RegWrite_i  in  1  EX/MEM register write enable
RDaddr_i  in  5  EX/MEM destination register
mem_req_o  out  1  data-memory request, held until ack
mem_we_o  out  1  1 = store, 0 = load
mem_addr_o  out  32  word-aligned byte address
mem_wdata_o  out  32  store data
mem_ack_i  in  1  data-memory completion, 1-cycle pulse
mem_rdata_i  in  32  load data, valid with mem_ack_i
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
branch_taken_o  out  1  redirect fetch to pc_branch_o
pc_branch_o  out  32  branch target passthrough
misalign_o  out  1  1-cycle pulse on misaligned access
err_o  out  1  sticky timeout error
RegWrite_o  out  1  MEM/WB register write enable
MemtoReg_o  out  1  MEM/WB writeback select
ALUResult_o  out  32  MEM/WB ALU result
MemData_o  out  32  MEM/WB load data
RDaddr_o  out  5  MEM/WB destination register

Behaviour:
- Reset (rst_i=0 at edge): state IDLE, wait counter 0, mem_req_o/mem_we_o/err_o 0, mem_addr_o/mem_wdata_o 0, all MEM/WB outputs 0. A reset mid-access drops mem_req_o at that edge; any later ack is ignored.
- access = MemRead_i | MemWrite_i. If both are set, treat as a store.
- misaligned = access & (ALUResult_i[1:0] != 0).
- FSM states: IDLE, WAIT, DONE.
- IDLE, no access: stall_o=0; MEM/WB captures inputs each edge (MemData_o=0).
- IDLE, aligned access:
  - stall_o=1 (combinational).
  - Next edge: WAIT; latch mem_req_o=1, mem_we_o, mem_addr_o=ALUResult_i, mem_wdata_o=RS2data_i; counter cleared.
- IDLE, misaligned access:
  - stall_o=0, misalign_o=1 this cycle, no memory request.
  - MEM/WB captures with RegWrite_o=0 and MemData_o=0.
- WAIT:
  - stall_o=1; counter increments each cycle.
  - mem_ack_i=1: next edge DONE, drop mem_req_o, capture mem_rdata_i into a load buffer (loads only).
  - Counter reaches TIMEOUT_CYCLES-1 without ack: next edge DONE, drop mem_req_o, set err_o, load buffer 0, mark abort.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stall_o=0.
  - Next edge: MEM/WB captures RegWrite_o = RegWrite_i & ~abort, MemData_o = load buffer; state IDLE.
- Bubbles: while stall_o=1, MEM/WB loads a bubble (RegWrite_o=0, others hold), so each instruction writes back exactly once.
- Minimum access cost: 2 stall cycles (ack in the first WAIT cycle); DONE is the completion cycle.
- mem_ack_i in IDLE or DONE: ignored.
- branch_taken_o = Branch_i & Zero_i & ~stall_o (combinational); pc_branch_o = pc_branch_i.
- err_o clears only on reset.

Decomposition:
- Package mem_stage_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2)
  - counter width derived from TIMEOUT_CYCLES (16 bits)
  - MEM/WB bundle field widths
- Sub-module mem_wb_reg: MEM/WB register with synchronous active-low reset and a bubble input forcing RegWrite_o=0.

Test Plan:
- Non-memory stream: RegWrite_i=1, RDaddr_i=5, ALUResult_i=0x10, MemtoReg_i=0 -> stall_o never 1; next cycle RegWrite_o=1, ALUResult_o=0x10, RDaddr_o=5.
- Load to 0x100, ack after 3 WAIT cycles with rdata 0xDEADBEEF:
  - mem_req_o=1 for exactly 3 cycles, mem_addr_o=0x100, mem_we_o=0.
  - stall_o=1 for 4 cycles.
  - Then one write: RegWrite_o=1, MemData_o=0xDEADBEEF, MemtoReg_o=1.
- Store to 0x40, RS2data_i=0x12345678, ack on first WAIT cycle -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o=1 for exactly 2 cycles, RegWrite_o=0.
- Misaligned load to 0x102 -> misalign_o=1 for 1 cycle, mem_req_o stays 0, no stall, RegWrite_o=0.
- Timeout with TIMEOUT_CYCLES=4, load, no ack -> mem_req_o high 4 cycles then 0; err_o=1 sticky; RegWrite_o=0; a late ack is ignored.
- Reset during WAIT, then Branch_i=1 with Zero_i=1 -> mem_req_o=0 after the reset edge, all outputs 0; after release, branch_taken_o=1 and pc_branch_o equals pc_branch_i.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM encoding, wait-counter width and the MEM/WB bundle.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
  localparam int CNT_W  = 16;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   mem_data;
    logic [REG_AW-1:0] rd_addr;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble holds the payload and suppresses the register write.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    bubble_i,
  input  mem_wb_t wb_i,
  output mem_wb_t wb_o
);

  mem_wb_t wb_d, wb_q;

  always_comb begin
    wb_d = wb_i;
    if (bubble_i) begin
      wb_d           = wb_q;
      wb_d.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) wb_q <= '0;
    else        wb_q <= wb_d;
  end

  assign wb_o = wb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: data-memory access over req/ack, upstream stall, branch resolve and MEM/WB register.
// Memory handshake: mem_req_o rises with address/data/we stable and stays high until the
// single-cycle mem_ack_i pulse; acks arriving while no request is outstanding are ignored.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic        Zero_i,
  input  logic [31:0] pc_branch_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemtoReg_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  RDaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        branch_taken_o,
  output logic [31:0] pc_branch_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      load_buf_q, load_buf_d;

  logic    access, misaligned, timeout_hit;
  logic    stall, misalign;
  mem_wb_t wb_in, wb_out;

  assign access      = MemRead_i | MemWrite_i;
  assign misaligned  = access & (ALUResult_i[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_buf_q  <= load_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    err_d       = err_q;
    abort_d     = abort_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_buf_d  = load_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (access && !misaligned) begin
          state_d     = ST_WAIT;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite_i;
          mem_addr_d  = ALUResult_i;
          mem_wdata_d = RS2data_i;
          abort_d     = 1'b0;
          load_buf_d  = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          load_buf_d = mem_we_q ? 32'h0 : mem_rdata_i;
        end else if (timeout_hit) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          err_d      = 1'b1;
          abort_d    = 1'b1;
          load_buf_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall            = 1'b0;
    misalign         = 1'b0;
    wb_in.reg_write  = RegWrite_i;
    wb_in.mem_to_reg = MemtoReg_i;
    wb_in.alu_result = ALUResult_i;
    wb_in.mem_data   = '0;
    wb_in.rd_addr    = RDaddr_i;
    case (state_q)
      ST_IDLE: begin
        stall    = access & ~misaligned;
        misalign = misaligned;
        if (misaligned) wb_in.reg_write = 1'b0;
      end
      ST_WAIT: stall = 1'b1;
      ST_DONE: begin
        wb_in.reg_write = RegWrite_i & ~abort_q;
        wb_in.mem_data  = load_buf_q;
      end
      default: stall = 1'b0;
    endcase
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (stall),
    .wb_i     (wb_in),
    .wb_o     (wb_out)
  );

  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign err_o          = err_q;
  assign stall_o        = stall;
  assign misalign_o     = misalign;
  assign branch_taken_o = Branch_i & Zero_i & ~stall;
  assign pc_branch_o    = pc_branch_i;
  assign RegWrite_o     = wb_out.reg_write;
  assign MemtoReg_o     = wb_out.mem_to_reg;
  assign ALUResult_o    = wb_out.alu_result;
  assign MemData_o      = wb_out.mem_data;
  assign RDaddr_o       = wb_out.rd_addr;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-instruction reference model with a writeback scoreboard.
module tb_mem_stage_ctrl;

  localparam int T = 4;

  logic        clk, rst_i;
  logic [31:0] ALUResult_i, RS2data_i, pc_branch_i, mem_rdata_i;
  logic        Zero_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, RegWrite_i, mem_ack_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o, mem_we_o, stall_o, branch_taken_o, misalign_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, pc_branch_o, ALUResult_o, MemData_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [4:0]  RDaddr_o;

  int n_checks = 0;
  int n_errors = 0;
  bit err_model = 1'b0;
  logic [69:0] exp_q[$];

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .Zero_i(Zero_i),
    .pc_branch_i(pc_branch_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
    .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .RDaddr_i(RDaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .branch_taken_o(branch_taken_o), .pc_branch_o(pc_branch_o),
    .misalign_o(misalign_o), .err_o(err_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALUResult_o(ALUResult_o),
    .MemData_o(MemData_o), .RDaddr_o(RDaddr_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every register write leaving MEM/WB must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_i && RegWrite_o) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {MemtoReg_o, ALUResult_o, MemData_o, RDaddr_o}, 70'h0);
      end else begin
        check("wb_packet", {MemtoReg_o, ALUResult_o, MemData_o, RDaddr_o}, exp_q.pop_front());
      end
    end
  end

  // Presents one EX/MEM instruction, serves the memory, returns just after its writeback edge.
  task automatic run_instr(input bit rd_en, input bit wr_en, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input bit rw,
                           input bit m2r, input int ack_lat, input logic [31:0] rdata,
                           input bit br, input bit zr, input bit stray_ack);
    bit access, mis, tmo, is_load, exp_stall;
    int nwait;
    logic [31:0] tgt;
    access    = rd_en | wr_en;
    mis       = access && (addr[1:0] != 2'b00);
    is_load   = rd_en && !wr_en;
    exp_stall = access && !mis;
    tmo       = exp_stall && (ack_lat < 1 || ack_lat > T);
    nwait     = tmo ? T : ack_lat;
    if (rw && !mis && !tmo)
      exp_q.push_back({m2r, addr, (is_load && exp_stall) ? rdata : 32'h0, rd});
    tgt = $urandom;
    MemRead_i = rd_en; MemWrite_i = wr_en; ALUResult_i = addr; RS2data_i = wdata;
    RDaddr_i = rd; RegWrite_i = rw; MemtoReg_i = m2r; Branch_i = br; Zero_i = zr;
    pc_branch_i = tgt; mem_ack_i = stray_ack; mem_rdata_i = $urandom;
    #1;
    check("stall_idle", stall_o, exp_stall);
    check("misalign", misalign_o, mis);
    check("req_idle", mem_req_o, 1'b0);
    check("err_idle", err_o, err_model);
    check("br_taken_idle", branch_taken_o, br && zr && !exp_stall);
    check("pc_branch", pc_branch_o, tgt);
    if (exp_stall) begin
      for (int c = 1; c <= nwait; c++) begin
        @(posedge clk); #1;
        mem_ack_i   = (c == ack_lat);
        mem_rdata_i = (c == ack_lat) ? rdata : $urandom;
        #1;
        check("stall_wait", stall_o, 1'b1);
        check("req_wait", mem_req_o, 1'b1);
        check("bubble_wait", RegWrite_o, 1'b0);
        check("br_taken_wait", branch_taken_o, 1'b0);
        if (c == 1) begin
          check("mem_addr", mem_addr_o, addr);
          check("mem_we", mem_we_o, wr_en);
          check("mem_wdata", mem_wdata_o, wdata);
        end
      end
      if (tmo) err_model = 1'b1;
      @(posedge clk); #1;
      mem_ack_i = 1'($urandom_range(0, 1));
      #1;
      check("stall_done", stall_o, 1'b0);
      check("req_done", mem_req_o, 1'b0);
      check("err_done", err_o, err_model);
      check("bubble_done", RegWrite_o, 1'b0);
      check("br_taken_done", branch_taken_o, br && zr);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int kind, lat;
    bit rd_en, wr_en, rw;
    logic [31:0] addr;

    rst_i = 1'b0; ALUResult_i = '0; RS2data_i = '0; Zero_i = 1'b0; pc_branch_i = '0;
    Branch_i = 1'b0; MemRead_i = 1'b0; MemtoReg_i = 1'b0; MemWrite_i = 1'b0;
    RegWrite_i = 1'b0; RDaddr_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", mem_req_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_err", err_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_memwb", {RegWrite_o, MemtoReg_o, ALUResult_o, MemData_o, RDaddr_o}, 70'h0);
    rst_i = 1'b1;

    // Directed: plain ALU op, load, store, misaligned load, timeout, stray ack afterwards
    run_instr(0, 0, 32'h10, 32'h0, 5'd5, 1, 0, 0, 32'h0, 0, 0, 0);
    run_instr(1, 0, 32'h100, 32'h0, 5'd7, 1, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    run_instr(0, 1, 32'h40, 32'h12345678, 5'd0, 0, 0, 1, 32'h0, 1, 1, 0);
    run_instr(1, 0, 32'h102, 32'h0, 5'd9, 1, 1, 1, 32'h0, 0, 0, 0);
    run_instr(1, 0, 32'h80, 32'h0, 5'd11, 1, 1, 0, 32'h0, 0, 0, 0);
    run_instr(0, 0, 32'h55, 32'h0, 5'd3, 1, 0, 0, 32'h0, 1, 1, 1);

    // Randomized stream
    for (int i = 0; i < 200; i++) begin
      kind  = $urandom_range(0, 3);
      rd_en = (kind == 1) || (kind == 3);
      wr_en = (kind >= 2);
      addr  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      lat = $urandom_range(1, T);
      if ($urandom_range(0, 9) == 0) lat = ($urandom_range(0, 1) == 1) ? 0 : T + 1;
      rw = wr_en ? 1'b0 : 1'($urandom_range(0, 1));
      run_instr(rd_en, wr_en, addr, $urandom, 5'($urandom_range(0, 31)), rw,
                1'($urandom_range(0, 1)), lat, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an access, then a taken branch
    MemRead_i = 1'b1; MemWrite_i = 1'b0; ALUResult_i = 32'h200; RegWrite_i = 1'b1;
    Branch_i = 1'b0; Zero_i = 1'b0; mem_ack_i = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_req_before", mem_req_o, 1'b1);
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req", mem_req_o, 1'b0);
    check("rst_mid_err", err_o, 1'b0);
    check("rst_mid_memwb", {RegWrite_o, MemtoReg_o, ALUResult_o, MemData_o, RDaddr_o}, 70'h0);
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1; err_model = 1'b0;
    MemRead_i = 1'b0; RegWrite_i = 1'b0; Branch_i = 1'b1; Zero_i = 1'b1;
    pc_branch_i = 32'hCAFE_0040;
    #1;
    check("post_rst_br_taken", branch_taken_o, 1'b1);
    check("post_rst_pc_branch", pc_branch_o, 32'hCAFE_0040);
    check("post_rst_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    #1;
    check("post_rst_req", mem_req_o, 1'b0);
    check("post_rst_err", err_o, 1'b0);

    // Drain and confirm every expected writeback happened exactly once
    Branch_i = 1'b0; Zero_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 70'(exp_q.size()), 70'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
